// File: rtl/siso_shift_arbiter.sv
// Round-robin arbiter that loads one of two parallel words and shifts it LSB-first
// into an external SISO right-shift chain, then flags the aligned word for one cycle.
module siso_shift_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  input  logic [WIDTH-1:0] i_req0_data,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [WIDTH-1:0] i_req1_data,
  output logic             o_req1_ready,
  input  logic             i_abort,
  output logic             o_sd,
  output logic             o_shift_en,
  output logic             o_busy,
  output logic             o_owner,
  output logic             o_word_valid
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner;
  logic             r_last;
  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;

  // On a tie the requester that did not win last time is served; grants are
  // masked during reset so every output reads zero while reset is held.
  always_comb begin
    w_idle   = (r_state == ST_IDLE);
    w_grant0 = i_rst_n && w_idle && i_req0_valid && (!i_req1_valid || r_last);
    w_grant1 = i_rst_n && w_idle && i_req1_valid && (!i_req0_valid || !r_last);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant0 || w_grant1) begin
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_abort) begin
          w_next = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // An abort leaves owner/last at the cancelled grant so the other side wins the next tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_sreg  <= w_grant1 ? i_req1_data : i_req0_data;
            r_owner <= w_grant1;
            r_last  <= w_grant1;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_shift_en   = (r_state == ST_SHIFT);
  assign o_sd         = (r_state == ST_SHIFT) && r_sreg[0];
  assign o_word_valid = (r_state == ST_HOLD);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_owner      = r_owner;

endmodule

// File: doc/siso_shift_arbiter.md
# siso_shift_arbiter

Shares one serial-in/serial-out right-shift register between two requesters. Grants a requester round-robin, captures its parallel word, and drives the chain's serial input and shift enable for exactly WIDTH cycles, LSB first. The captured word then sits aligned in the chain, and the block flags it with a one-cycle `word_valid` tagged with the owner. The block sits directly in front of the SISO chain, which extends the existing chain with a shift-enable input: MSB-side entry, q <= {d, q[WIDTH-1:1]} when enabled.

## Interface
- `WIDTH`, default 4. Word and chain length in bits; legal values are ≥ 2.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a word.
- `req0_data` in WIDTH: requester 0 word.
- `req0_ready` out 1: requester 0 word captured this cycle.
- `req1_valid` in 1: requester 1 has a word.
- `req1_data` in WIDTH: requester 1 word.
- `req1_ready` out 1: requester 1 word captured this cycle.
- `abort` in 1: synchronous cancel of the shift in progress.
- `sd` out 1: serial data to the chain `d`.
- `shift_en` out 1: chain shift enable.
- `busy` out 1: high when the state is not IDLE.
- `owner` out 1: index of the current or last granted requester.
- `word_valid` out 1: chain holds the complete word of `owner`.

## Operation
- States: IDLE, SHIFT, HOLD.
- Internal registers:
  - `sreg[WIDTH-1:0]`
  - bit counter `cnt`, $clog2(WIDTH) bits
  - `last`, the last winner
- IDLE, grant rules:
  - Only one requester valid: that requester wins.
  - Both valid: the requester ≠ `last` wins.
- IDLE, grant action:
  - `reqN_ready` for the winner is combinationally high in that cycle.
  - The capture happens on that edge: `sreg` <= `reqN_data`, `owner` <= N, `last` <= N, `cnt` <= 0, and the state goes to SHIFT.
  - No valid request: stay in IDLE.
- SHIFT:
  - `shift_en`=1 and `sd`=`sreg[0]`.
  - Each edge: `sreg` shifts right, zero-filled, and `cnt` increments.
  - At `cnt`==WIDTH-1 the state goes to HOLD.
- HOLD: `word_valid`=1 and `shift_en`=0 for one cycle, then IDLE.
- Both ready outputs are 0 outside IDLE. A requester holds `valid` and `data` stable until ready. Deasserting `valid` before ready is allowed and causes no capture.
- `abort`:
  - Sampled only in SHIFT. When high, the next state is IDLE, with no HOLD and no `word_valid`.
  - `last` and `owner` keep the aborted grant, so the other requester wins the next tie.
  - The chain holds a partially shifted word; it is not cleared.
  - In IDLE and HOLD, `abort` is ignored.
- `abort` at `cnt`==WIDTH-1 also suppresses HOLD.
- Reset (`rst`=0, at any time including mid-SHIFT) forces the following, immediately:
  - state IDLE
  - `sreg`=0, `cnt`=0
  - `owner`=0
  - `last`=1, so requester 0 wins the first tie
- Reset values of the outputs: `sd`=0, `shift_en`=0, `busy`=0, `owner`=0, `word_valid`=0, `req0_ready`=0, `req1_ready`=0.

## Timing
- Cycle G (IDLE): ready pulses and the word is captured at the end of G.
- Cycles G+1 .. G+WIDTH: `shift_en`=1, and `sd` carries bit0 .. bit(WIDTH-1).
- Cycle G+WIDTH+1: `word_valid`=1. Chain `q` equals the captured word.
- Cycle G+WIDTH+2: IDLE, and the earliest next grant.
- Minimum grant spacing is WIDTH+2 cycles.
- `busy` is high from G+1 through G+WIDTH+1.
- `sd`, `shift_en` and `word_valid` are decoded from registered state/`sreg` only. Ready depends combinationally on `valid` and state.

## Test plan
- Reset: assert `rst`=0 mid-test → all outputs 0 within the same cycle. After release with both valid, requester 0 is granted first.
- Single grant: `req0_data`=4'b1011, `req0_valid`=1 → `req0_ready` high for 1 cycle; `sd` = 1,1,0,1 over 4 `shift_en` cycles; `word_valid`=1 with `owner`=0 and chain `q`=1011.
- Contention: both valid from reset, `req0_data`=4'h5, `req1_data`=4'hA → requester 0 served first (q=0101). Then `req1_ready` appears exactly 6 cycles after `req0_ready`, `owner`=1, q=1010.
- Fairness: both held valid for 4 grants → owners 0,1,0,1. Requester 0 alone for 3 grants → 0,0,0 at 6-cycle spacing.
- Abort: requester 0 granted with data 4'hF, `abort`=1 in the 2nd SHIFT cycle → `shift_en`=0 and `busy`=0 next cycle, no `word_valid`. With both valid next, requester 1 wins.
- Abort ignored: `abort`=1 during HOLD and during IDLE → `word_valid` still pulses and the grant is unaffected.
